// File: rtl/dmem_if.sv
// MEM-stage data memory bus.
// Request in, registered response out.
interface dmem_if #(
  parameter int XLEN = 32
);
  logic            mem_en;
  logic            mem_wr;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [2:0]      funct3;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;
  logic            mem_err;
  logic            busy;

  modport master (
    output mem_en, mem_wr, addr, wdata, funct3,
    input  mem_data, mem_ready, mem_err, busy
  );

  modport slave (
    input  mem_en, mem_wr, addr, wdata, funct3,
    output mem_data, mem_ready, mem_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder with wait states.
// Byte/half/word access to a word RAM.
module dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [XLEN:0] LIMIT =
    (XLEN+1)'(DEPTH_WORDS * 4);
  localparam logic [3:0] WLAST =
    4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam state_t FIRST =
    (WAIT_STATES > 0) ? S_WAIT : S_RESP;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wr_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] wd_q;
  logic [2:0]      f3_q;

  logic [XLEN-1:0] ram [DEPTH_WORDS];
  logic [AW-1:0]   widx;
  logic [XLEN-1:0] rd_word;
  logic [XLEN-1:0] wword;
  logic [XLEN-1:0] ld_val;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic            err;
  logic            accept;
  logic            resp;

  logic            rdy_q;
  logic            err_q;
  logic [XLEN-1:0] data_q;

  assign accept = bus.mem_en &&
    (state_q == S_IDLE || state_q == S_RESP);
  assign resp = (state_q == S_RESP);

  assign widx    = a_q[AW+1:2];
  assign rd_word = ram[widx];

  // State and wait counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: WAIT lasts WAIT_STATES cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) state_d = FIRST;
      end
      S_WAIT: begin
        if (cnt_q == WLAST) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        cnt_d   = '0;
        state_d = accept ? FIRST : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Capture the request when it is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= 1'b0;
      a_q  <= '0;
      wd_q <= '0;
      f3_q <= '0;
    end else if (accept) begin
      wr_q <= bus.mem_wr;
      a_q  <= bus.addr;
      wd_q <= bus.wdata;
      f3_q <= bus.funct3;
    end
  end

  // Alignment, range and funct3 legality
  always_comb begin
    logic mis;
    logic oor;
    logic bad;
    mis = (f3_q[1:0] == 2'd1 && a_q[0]) ||
          (f3_q[1:0] == 2'd2 && a_q[1:0] != 2'd0);
    oor = ({1'b0, a_q} >= LIMIT);
    if (wr_q) bad = (f3_q > 3'd2);
    else      bad = (f3_q == 3'd3) ||
                    (f3_q == 3'd6) ||
                    (f3_q == 3'd7);
    err = mis || oor || bad;
  end

  // Lane select and extension for loads
  always_comb begin
    ld_b   = rd_word[{a_q[1:0], 3'b000} +: 8];
    ld_h   = rd_word[{a_q[1], 4'b0000} +: 16];
    ld_val = '0;
    unique case (f3_q)
      3'd0: ld_val = {{(XLEN-8){ld_b[7]}}, ld_b};
      3'd1: ld_val = {{(XLEN-16){ld_h[15]}}, ld_h};
      3'd2: ld_val = rd_word;
      3'd4: ld_val = {{(XLEN-8){1'b0}}, ld_b};
      3'd5: ld_val = {{(XLEN-16){1'b0}}, ld_h};
      default: ld_val = '0;
    endcase
  end

  // Merge store data into the addressed lanes
  always_comb begin
    wword = rd_word;
    unique case (f3_q[1:0])
      2'd0: wword[{a_q[1:0], 3'b000} +: 8] = wd_q[7:0];
      2'd1: wword[{a_q[1], 4'b0000} +: 16] = wd_q[15:0];
      default: wword = wd_q;
    endcase
  end

  // RAM commit; contents survive reset
  always_ff @(posedge clk) begin
    if (rst_n && resp && wr_q && !err)
      ram[widx] <= wword;
  end

  // Registered response, one pulse per access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
    end else begin
      rdy_q <= resp;
      err_q <= resp && err;
      if (resp && (err || !wr_q))
        data_q <= err ? '0 : ld_val;
    end
  end

  assign bus.mem_ready = rdy_q;
  assign bus.mem_err   = err_q;
  assign bus.mem_data  = data_q;
  assign bus.busy      = (state_q == S_WAIT) ||
                         (resp && !bus.mem_en);
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the MEM stage. It accepts the stage's request (enable, write, address from the ALU result, store data from rs2) and performs byte, halfword or word stores and loads against an internal word-organised RAM. It returns load data on mem_data with a ready/error handshake after a configurable number of wait states. It lets the pipeline be exercised against a realistic, non-zero-latency memory.

Parameters:
XLEN, 32, data/address width.
DEPTH_WORDS, 1024, RAM depth in XLEN-bit words; valid byte addresses are 0 to DEPTH_WORDS*4-1.
WAIT_STATES, 1, extra cycles between accepting a request and responding (0 to 15).

Ports:
clk  in  1  single system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
mem_en  in  1  request strobe; sampled only when the block is able to accept.
mem_wr  in  1  1 = store, 0 = load; qualified by mem_en.
addr  in  XLEN  byte address (the MEM stage ALU result).
wdata  in  XLEN  store data (rs2); low bytes are used for SB/SH.
funct3  in  3  access size/sign: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
mem_data  out  XLEN  load result, extended to XLEN.
mem_ready  out  1  one-cycle response pulse.
mem_err  out  1  error flag, valid with mem_ready.
busy  out  1  high while a request is held and not yet answered.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; mem_data, mem_ready, mem_err and busy = 0; wait counter = 0.
  - RAM contents are not reset.
- Reset asserted mid-transaction drops the request: no RAM write occurs and no response is issued.
- States:
  - IDLE: mem_en=1 latches mem_wr, addr, wdata and funct3. Next state is WAIT if WAIT_STATES>0, otherwise RESP.
  - WAIT: counter counts WAIT_STATES cycles, then moves to RESP. mem_en is ignored in this state.
  - RESP: mem_ready=1 for this single cycle and the access is committed. mem_en=1 here is accepted as the next request (same latch and next-state rules as IDLE); otherwise the next state is IDLE.
- busy = 1 in WAIT, and in RESP unless a new request is accepted that cycle.
- Latency: mem_ready rises WAIT_STATES+1 cycles after the accepting edge. Back-to-back throughput is one access per WAIT_STATES+1 cycles.
- Error check, evaluated on the latched request. Error if any of:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr >= DEPTH_WORDS*4;
  - load with funct3 in {3, 6, 7};
  - store with funct3 not in {0, 1, 2}.
- On error: mem_err=1 with mem_ready, the RAM is not modified, and mem_data = 0.
- Store (no error): at the RESP edge, write word addr[..:2] with byte enables:
  - SB: lane addr[1:0] gets wdata[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - SW: all four lanes get wdata.
  - Unaddressed bytes keep their value.
  - mem_data is unchanged; mem_err = 0.
- Load (no error): mem_data is registered at the RESP edge from the selected lane(s). LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through. mem_err = 0.
- mem_data holds its last value until the next load or error response.
- mem_err is 0 whenever mem_ready is 0.
- A load that immediately follows a store to the same word returns the stored data. The write commits before the later read, because accesses are serialised.

Test Plan:
- Reset, then SW addr=0x10, wdata=0xDEADBEEF, then LW 0x10 (WAIT_STATES=1) -> mem_ready exactly 2 cycles after each accept; load returns mem_data=0xDEADBEEF, mem_err=0.
- After the above, SB addr=0x11, wdata=0x000000AA, then LW 0x10 -> 0xDEADAAEF. Then LB 0x11 -> 0xFFFFFFAA; LBU 0x11 -> 0x000000AA.
- SH addr=0x22, wdata=0x8001 over an initial word 0x00000000, then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LW 0x20 -> 0x80010000.
- Errors:
  - LW 0x13 -> mem_err=1, mem_data=0.
  - SW 0x1000 (DEPTH_WORDS=1024) -> mem_err=1, and a following LW 0x0 shows word 0 unchanged.
  - Load with funct3=3 -> mem_err=1.
- Hold mem_en=1 continuously with WAIT_STATES=0 and 4 loads -> one mem_ready per cycle with correct data each cycle; busy stays 0.
- Assert rst_n=0 while in WAIT during an SW to 0x40 -> outputs go to 0 immediately; no mem_ready pulse; a later LW 0x40 returns the old contents.
